// File: rtl/trigger_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_seq_pkg
//  Purpose  : Shared types and constants for the trigger sequencer: FSM state
//             encoding, trigger-mode values and control-register bit indices
//             of the register bank that drives the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package trigger_seq_pkg;

    // FSM state encoding, also exported on state_dbg
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DELAY   = 3'd1,
        RUN_INT = 3'd2,
        RUN_EXT = 3'd3
    } state_t;

    // cfg_mode values
    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_EXT = 1'b1;

    // Bit positions in the control register feeding cfg_*/cmd_*
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_MODE_BIT  = 1;
    localparam int CTRL_CONT_BIT  = 2;
    localparam int CTRL_START_BIT = 3;
    localparam int CTRL_STOP_BIT  = 4;

endpackage
`default_nettype wire

// File: rtl/trig_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module   : trig_sync_edge
//  Purpose  : Multi-flop synchronizer for an asynchronous trigger level plus a
//             rising-edge detector on the synchronized output.
//  Ports    : clk_i   - clock
//             rst_i   - asynchronous active-high reset (all flops to 0)
//             async_i - asynchronous input level
//             rise_o  - high for one cycle when the synchronized level
//                       goes 0->1 (SYNC_STAGES edges after the input rise)
//  Revision : 1.0  initial release
// ============================================================================
module trig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic async_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Both terms are flop outputs, so the detect is glitch-free.
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : trigger_sequencer
//  Purpose  : Trigger sequencing core. Issues registered single-cycle pulses
//             on trig_out, either internally (delay then periodic burst) or
//             from a synchronized, holdoff-filtered external trigger.
//  Ports    : ACLK/ARESET          - clock, async active-high reset
//             cfg_*                - configuration, shadowed at start
//             cmd_start/cmd_stop   - single-cycle command strobes
//             ext_trig             - asynchronous external trigger level
//             trig_out             - trigger pulse
//             busy/done/aborted    - run status
//             trig_cnt/missed_cnt  - pulses issued / external edges dropped
//             state_dbg            - current FSM state
//  Revision : 1.0  initial release
// ============================================================================
module trigger_sequencer
    import trigger_seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MISS_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              cfg_enable,
    input  logic              cfg_mode,
    input  logic              cfg_continuous,
    input  logic [CNT_W-1:0]  cfg_delay,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              cmd_start,
    input  logic              cmd_stop,
    input  logic              ext_trig,
    output logic              trig_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  trig_cnt,
    output logic [MISS_W-1:0] missed_cnt,
    output logic [2:0]        state_dbg
);

    localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [MISS_W-1:0] c_miss_one = {{(MISS_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;          // shared delay/period/holdoff
    logic [CNT_W-1:0]    period_q, period_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                mode_q, mode_d;
    logic                cont_q, cont_d;
    logic [CNT_W-1:0]    trig_cnt_q, trig_cnt_d;
    logic [MISS_W-1:0]   missed_q, missed_d;
    logic                aborted_q, aborted_d;
    logic                last_q, last_d;        // final pulse issued, done due
    logic                done_q, done_d;
    logic                trig_q, trig_d;

    logic                w_rise;
    logic                w_start_ok;
    logic                w_zero_run;
    logic                w_abort;
    logic                w_active;
    logic                w_fire;
    logic                w_drop;
    logic                w_final;
    logic                w_issue;
    logic [CNT_W-1:0]    w_trig_inc;

    trig_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .async_i (ext_trig),
        .rise_o  (w_rise)
    );

    assign w_start_ok = cmd_start & cfg_enable & ~cmd_stop;
    assign w_zero_run = ~cfg_continuous & (cfg_count == '0);
    assign w_abort    = (state_q != IDLE) & (cmd_stop | ~cfg_enable);

    // No new pulses once the final one is out and done is pending.
    assign w_active   = ~last_q & ~done_q;
    assign w_fire     = w_active & (cnt_q == '0) &
                        ((state_q == RUN_INT) | ((state_q == RUN_EXT) & w_rise));
    assign w_drop     = (state_q == RUN_EXT) & w_active & w_rise & (cnt_q != '0);
    assign w_trig_inc = trig_cnt_q + c_cnt_one;
    assign w_final    = ~cont_q & (w_trig_inc == count_q);
    // An abort suppresses a pending pulse unless it is the last of the run.
    assign w_issue    = w_fire & (~w_abort | w_final);

    // ---------------------------------------------------------------- state
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (w_start_ok && !w_zero_run) begin
                    if (cfg_delay == '0) begin
                        state_d = (cfg_mode == MODE_EXT) ? RUN_EXT : RUN_INT;
                    end else begin
                        state_d = DELAY;
                    end
                end
            end
            DELAY: begin
                if (w_abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    state_d = (mode_q == MODE_EXT) ? RUN_EXT : RUN_INT;
                end
            end
            RUN_INT, RUN_EXT: begin
                // done_q high means the done pulse is out this cycle
                if (w_abort || done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------- outputs / datapath
    always_comb begin
        cnt_d      = cnt_q;
        period_d   = period_q;
        count_d    = count_q;
        mode_d     = mode_q;
        cont_d     = cont_q;
        trig_cnt_d = trig_cnt_q;
        missed_d   = missed_q;
        aborted_d  = aborted_q;
        last_d     = last_q;
        done_d     = 1'b0;
        trig_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // A zero-length run parks last_q here to emit done next cycle
                done_d = last_q;
                last_d = 1'b0;
                if (w_start_ok) begin
                    period_d   = (cfg_period == '0) ? c_cnt_one : cfg_period;
                    count_d    = cfg_count;
                    mode_d     = cfg_mode;
                    cont_d     = cfg_continuous;
                    trig_cnt_d = '0;
                    missed_d   = '0;
                    aborted_d  = 1'b0;
                    last_d     = w_zero_run;
                    // DELAY exits on the edge after cnt reaches zero
                    cnt_d      = (cfg_delay == '0) ? '0 : (cfg_delay - c_cnt_one);
                end
            end
            DELAY: begin
                if (w_abort) begin
                    aborted_d = 1'b1;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end
            end
            RUN_INT, RUN_EXT: begin
                last_d = 1'b0;
                done_d = last_q & ~w_abort;
                if (w_abort && !done_q) begin
                    aborted_d = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - c_cnt_one;
                end
                if (w_issue) begin
                    trig_d     = 1'b1;
                    trig_cnt_d = w_trig_inc;
                    // Internal: fire again P edges later. External: holdoff
                    // stays nonzero for the P cycles starting at the pulse.
                    cnt_d      = (state_q == RUN_INT) ? (period_q - c_cnt_one) : period_q;
                    last_d     = w_final & ~w_abort;
                end
                if (w_drop && (missed_q != '1)) begin
                    missed_d = missed_q + c_miss_one;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            cnt_q      <= '0;
            period_q   <= '0;
            count_q    <= '0;
            mode_q     <= 1'b0;
            cont_q     <= 1'b0;
            trig_cnt_q <= '0;
            missed_q   <= '0;
            aborted_q  <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            trig_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            count_q    <= count_d;
            mode_q     <= mode_d;
            cont_q     <= cont_d;
            trig_cnt_q <= trig_cnt_d;
            missed_q   <= missed_d;
            aborted_q  <= aborted_d;
            last_q     <= last_d;
            done_q     <= done_d;
            trig_q     <= trig_d;
        end
    end

    assign trig_out   = trig_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign trig_cnt   = trig_cnt_q;
    assign missed_cnt = missed_q;
    assign state_dbg  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_trigger_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_trigger_sequencer
//  Purpose  : Directed self-checking bench for trigger_sequencer (CNT_W=4 so
//             the continuous-mode counter wrap is reachable).
//             Cycle n is the interval after the n-th rising edge counted from
//             the edge that samples cmd_start; outputs are sampled mid-cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_trigger_sequencer;

    localparam int CNT_W  = 4;
    localparam int MISS_W = 8;

    logic              clk = 1'b0;
    logic              ARESET;
    logic              cfg_enable, cfg_mode, cfg_continuous;
    logic [CNT_W-1:0]  cfg_delay, cfg_period, cfg_count;
    logic              cmd_start, cmd_stop, ext_trig;
    logic              trig_out, busy, done, aborted;
    logic [CNT_W-1:0]  trig_cnt;
    logic [MISS_W-1:0] missed_cnt;
    logic [2:0]        state_dbg;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    logic [31:0] tm, dm, bm;

    always #5 clk = ~clk;

    trigger_sequencer #(
        .CNT_W       (CNT_W),
        .MISS_W      (MISS_W),
        .SYNC_STAGES (2)
    ) dut (
        .ACLK           (clk),
        .ARESET         (ARESET),
        .cfg_enable     (cfg_enable),
        .cfg_mode       (cfg_mode),
        .cfg_continuous (cfg_continuous),
        .cfg_delay      (cfg_delay),
        .cfg_period     (cfg_period),
        .cfg_count      (cfg_count),
        .cmd_start      (cmd_start),
        .cmd_stop       (cmd_stop),
        .ext_trig       (ext_trig),
        .trig_out       (trig_out),
        .busy           (busy),
        .done           (done),
        .aborted        (aborted),
        .trig_cnt       (trig_cnt),
        .missed_cnt     (missed_cnt),
        .state_dbg      (state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic en, input logic mode, input logic cont,
                           input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] p,
                           input logic [CNT_W-1:0] c);
        cfg_enable     = en;
        cfg_mode       = mode;
        cfg_continuous = cont;
        cfg_delay      = d;
        cfg_period     = p;
        cfg_count      = c;
    endtask

    // cmd_start must already be set; it is sampled by edge 0. Config is
    // scrambled after edge 0 to show the shadow copy is used. A nonzero
    // stop_at makes cmd_stop sampled by edge stop_at.
    task automatic run_win(input int n, input int stop_at,
                           output logic [31:0] t_m, output logic [31:0] d_m,
                           output logic [31:0] b_m);
        t_m = '0; d_m = '0; b_m = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            if (i == 0) begin
                cfg_delay  = 4'd7;
                cfg_period = 4'd2;
                cfg_count  = 4'd1;
            end
            cmd_stop = (i + 1 == stop_at);
            t_m[i] = trig_out;
            d_m[i] = done;
            b_m[i] = busy;
        end
        cmd_stop = 1'b0;
    endtask

    initial begin
        ARESET    = 1'b1;
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        ext_trig  = 1'b0;
        set_cfg(1'b0, 1'b0, 1'b0, '0, '0, '0);

        // ---- reset state
        repeat (2) @(negedge clk);
        chk("rst_trig",    trig_out,   0);
        chk("rst_busy",    busy,       0);
        chk("rst_done",    done,       0);
        chk("rst_aborted", aborted,    0);
        chk("rst_trigcnt", trig_cnt,   0);
        chk("rst_missed",  missed_cnt, 0);
        chk("rst_state",   state_dbg,  0);
        ARESET = 1'b0;
        @(negedge clk);

        // ---- internal D=3 P=4 count=3: pulses 4,8,12, done 13, idle 14
        set_cfg(1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd3);
        cmd_start = 1'b1;
        run_win(16, 0, tm, dm, bm);
        chk("int_trig_mask", tm, 32'h0000_1110);
        chk("int_done_mask", dm, 32'h0000_2000);
        chk("int_busy_mask", bm, 32'h0000_3FFF);
        chk("int_trigcnt",   trig_cnt, 3);
        chk("int_aborted",   aborted,  0);
        chk("int_state",     state_dbg, 0);

        // ---- stop sampled at edge 6: only the pulse at 4
        set_cfg(1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd3);
        cmd_start = 1'b1;
        run_win(12, 6, tm, dm, bm);
        chk("stop_trig_mask", tm, 32'h0000_0010);
        chk("stop_done_mask", dm, 32'h0000_0000);
        chk("stop_busy_mask", bm, 32'h0000_003F);
        chk("stop_aborted",   aborted,  1);
        chk("stop_trigcnt",   trig_cnt, 1);

        // ---- start and stop together: stays idle, aborted untouched
        cmd_start = 1'b1;
        cmd_stop  = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
        cmd_stop  = 1'b0;
        chk("ss_busy",    busy,      0);
        chk("ss_state",   state_dbg, 0);
        chk("ss_aborted", aborted,   1);
        repeat (2) @(negedge clk);
        chk("ss_busy_later", busy, 0);

        // ---- stop on the edge of the final pulse: pulse out, no done
        set_cfg(1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd3);
        cmd_start = 1'b1;
        run_win(16, 12, tm, dm, bm);
        chk("fstop_trig_mask", tm, 32'h0000_1110);
        chk("fstop_done_mask", dm, 32'h0000_0000);
        chk("fstop_busy_mask", bm, 32'h0000_0FFF);
        chk("fstop_aborted",   aborted,  1);
        chk("fstop_trigcnt",   trig_cnt, 3);

        // ---- D=0 P=0 count=2: pulses 1,2, done 3
        set_cfg(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd2);
        cmd_start = 1'b1;
        run_win(8, 0, tm, dm, bm);
        chk("d0_trig_mask", tm, 32'h0000_0006);
        chk("d0_done_mask", dm, 32'h0000_0008);
        chk("d0_busy_mask", bm, 32'h0000_000F);
        chk("d0_trigcnt",   trig_cnt, 2);
        chk("d0_aborted",   aborted,  0);

        // ---- count=0: done in cycle 1 only, never busy, no trigger
        set_cfg(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
        cmd_start = 1'b1;
        run_win(6, 0, tm, dm, bm);
        chk("c0_trig_mask", tm, 32'h0000_0000);
        chk("c0_done_mask", dm, 32'h0000_0002);
        chk("c0_busy_mask", bm, 32'h0000_0000);
        chk("c0_trigcnt",   trig_cnt, 0);

        // ---- external D=0 P=10, six edges 4 cycles apart
        // ext rises in cycle 2 -> triggers in cycle 5 (three edges later);
        // detects at 4,8,12,16,20,24 -> pulses at 5 and 17, four dropped.
        set_cfg(1'b1, 1'b1, 1'b0, 4'd0, 4'd10, 4'd10);
        cmd_start = 1'b1;
        tm = '0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            tm[i] = trig_out;
            ext_trig = (i >= 2) && (i < 24) && ((i % 4 == 2) || (i % 4 == 3));
        end
        ext_trig = 1'b0;
        chk("ext_trig_mask", tm, 32'h0002_0020);
        chk("ext_trigcnt",   trig_cnt,   2);
        chk("ext_missed",    missed_cnt, 4);
        chk("ext_busy",      busy,       1);
        cmd_stop = 1'b1;
        @(negedge clk);
        cmd_stop = 1'b0;
        chk("ext_stop_busy",    busy,     0);
        chk("ext_stop_aborted", aborted,  1);
        chk("ext_stop_trig",    trig_out, 0);

        // ---- external D=8 P=1 count=1: edge during DELAY ignored
        set_cfg(1'b1, 1'b1, 1'b0, 4'd8, 4'd1, 4'd1);
        cmd_start = 1'b1;
        tm = '0; dm = '0; bm = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cmd_start = 1'b0;
            tm[i] = trig_out;
            dm[i] = done;
            bm[i] = busy;
            ext_trig = (i == 1) || (i == 2) || (i == 10) || (i == 11);
        end
        ext_trig = 1'b0;
        chk("extd_trig_mask", tm, 32'h0000_2000);
        chk("extd_done_mask", dm, 32'h0000_4000);
        chk("extd_busy_mask", bm, 32'h0000_7FFF);
        chk("extd_missed",    missed_cnt, 0);
        chk("extd_aborted",   aborted,    0);

        // ---- continuous P=1: trig_cnt wraps 15 -> 0 while busy
        set_cfg(1'b1, 1'b0, 1'b1, 4'd0, 4'd1, 4'd0);
        cmd_start = 1'b1;
        run_win(16, 0, tm, dm, bm);
        chk("cont_trig_mask", tm, 32'h0000_FFFE);
        chk("cont_trigcnt15", trig_cnt, 15);
        chk("cont_done_mask", dm, 32'h0000_0000);
        @(negedge clk);
        chk("cont_wrap_cnt",  trig_cnt, 0);
        chk("cont_wrap_busy", busy,     1);
        chk("cont_wrap_trig", trig_out, 1);
        cfg_enable = 1'b0;
        @(negedge clk);
        chk("dis_busy",    busy,     0);
        chk("dis_trig",    trig_out, 0);
        chk("dis_aborted", aborted,  1);
        chk("dis_trigcnt", trig_cnt, 0);

        // ---- asynchronous reset mid-run, then a clean rerun
        set_cfg(1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd3);
        cmd_start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            cmd_start = 1'b0;
        end
        chk("ar_pre_trig", trig_out, 1);
        #2 ARESET = 1'b1;
        #1;
        chk("ar_trig",    trig_out,  0);
        chk("ar_busy",    busy,      0);
        chk("ar_trigcnt", trig_cnt,  0);
        chk("ar_state",   state_dbg, 0);
        @(negedge clk);
        ARESET = 1'b0;
        chk("ar_done",    done,    0);
        chk("ar_aborted", aborted, 0);
        set_cfg(1'b1, 1'b0, 1'b0, 4'd3, 4'd4, 4'd3);
        cmd_start = 1'b1;
        run_win(16, 0, tm, dm, bm);
        chk("ar_rerun_trig_mask", tm, 32'h0000_1110);
        chk("ar_rerun_done_mask", dm, 32'h0000_2000);
        chk("ar_rerun_busy_mask", bm, 32'h0000_3FFF);
        chk("ar_rerun_trigcnt",   trig_cnt, 3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
